// File: rtl/clock_set_ctrl.sv
// Front-panel set-mode controller for the digital clock.
// Debounces the MODE and INC keys, walks the run/set-time/set-alarm mode
// ring, produces adjust pulses with press-and-hold auto-repeat, blinks the
// field under edit and falls back to RUN after an idle timeout.
// Pulse semantics: adj_min, adj_hour and sec_clr are single-cycle strobes
// with no handshake; the consumer must act on every cycle they are high.
// The FSM state is exposed directly on the mode output.
module clock_set_ctrl #(
  parameter int DEB_CYCLES   = 1000000,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000,
  parameter int TIMEOUT_SEC  = 30,
  parameter int BLINK_HALF   = 12500000
) (
  input  logic       clk_50,
  input  logic       ncr,
  input  logic       tick_1hz,
  input  logic       key_mode,
  input  logic       key_inc,
  output logic [2:0] mode,
  output logic       set_al,
  output logic       run_en,
  output logic       adj_min,
  output logic       adj_hour,
  output logic       sec_clr,
  output logic       blank_min,
  output logic       blank_hour
);

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_T_HOUR = 3'd1,
    ST_T_MIN  = 3'd2,
    ST_A_HOUR = 3'd3,
    ST_A_MIN  = 3'd4
  } state_e;

  localparam logic [31:0] DEB_MAX   = 32'(DEB_CYCLES);
  localparam logic [31:0] DELAY_MAX = 32'(REPEAT_DELAY);
  localparam logic [31:0] RATE_MAX  = 32'(REPEAT_RATE);
  localparam logic [31:0] TO_MAX    = 32'(TIMEOUT_SEC);
  localparam logic [31:0] BLINK_MAX = 32'(BLINK_HALF);

  // Key index: bit 0 = MODE, bit 1 = INC.
  logic [1:0]       sync1_q, sync2_q;
  logic [1:0]       deb_q, deb_d;
  logic [1:0]       press_q, press_d;
  logic [1:0][31:0] deb_cnt_q, deb_cnt_d;

  state_e      state_q, state_d;
  logic [31:0] to_cnt_q, to_cnt_d;
  logic [31:0] rep_cnt_q, rep_cnt_d;
  logic [31:0] blink_cnt_q, blink_cnt_d;
  logic        rep_arm_q, rep_arm_d;
  logic        rep_first_q, rep_first_d;
  logic        phase_off_q, phase_off_d;
  logic        set_al_q, set_al_d;
  logic        run_en_q, run_en_d;
  logic        adj_min_q, adj_min_d;
  logic        adj_hour_q, adj_hour_d;
  logic        sec_clr_q, sec_clr_d;
  logic        blank_min_q, blank_min_d;
  logic        blank_hour_q, blank_hour_d;
  logic        state_chg, fire, edit, hour_fld;

  function automatic logic is_hour(input state_e s);
    return (s == ST_T_HOUR) || (s == ST_A_HOUR);
  endfunction

  function automatic logic is_min(input state_e s);
    return (s == ST_T_MIN) || (s == ST_A_MIN);
  endfunction

  // Debounce: the level follows the synchronized key only after it has
  // disagreed for DEB_CYCLES consecutive cycles; any agreement restarts.
  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = '0;
    for (int k = 0; k < 2; k++) begin
      if (sync2_q[k] != deb_q[k]) begin
        if (deb_cnt_q[k] + 32'd1 == DEB_MAX) begin
          deb_d[k] = sync2_q[k];
        end else begin
          deb_cnt_d[k] = deb_cnt_q[k] + 32'd1;
        end
      end
    end
    press_d = deb_d & ~deb_q;
  end

  // Mode FSM, timeout, adjust/auto-repeat and blink next-state logic.
  always_comb begin
    state_d     = state_q;
    to_cnt_d    = to_cnt_q;
    rep_cnt_d   = rep_cnt_q;
    rep_arm_d   = rep_arm_q;
    rep_first_d = rep_first_q;
    blink_cnt_d = blink_cnt_q;
    phase_off_d = phase_off_q;
    fire        = 1'b0;
    edit        = (state_q != ST_RUN);
    hour_fld    = is_hour(state_q);

    // MODE press beats both timeout and a coincident INC press.
    if (press_q[0]) begin
      case (state_q)
        ST_RUN:    state_d = ST_T_HOUR;
        ST_T_HOUR: state_d = ST_T_MIN;
        ST_T_MIN:  state_d = ST_A_HOUR;
        ST_A_HOUR: state_d = ST_A_MIN;
        default:   state_d = ST_RUN;
      endcase
    end else if (edit && !press_q[1] && tick_1hz && (to_cnt_q + 32'd1 == TO_MAX)) begin
      state_d = ST_RUN;
    end
    state_chg = (state_d != state_q);

    if (press_q[0] || press_q[1] || state_chg) begin
      to_cnt_d = '0;
    end else if (edit && tick_1hz) begin
      to_cnt_d = to_cnt_q + 32'd1;
    end

    // Repeat is cancelled by release of INC or by any state change.
    if (state_chg || !deb_q[1]) begin
      rep_arm_d = 1'b0;
      rep_cnt_d = '0;
    end
    if (press_q[1] && !press_q[0] && edit) begin
      fire        = 1'b1;
      rep_arm_d   = 1'b1;
      rep_first_d = 1'b1;
      rep_cnt_d   = '0;
    end else if (rep_arm_q && deb_q[1] && !state_chg) begin
      if (rep_cnt_q + 32'd1 == (rep_first_q ? DELAY_MAX : RATE_MAX)) begin
        fire        = 1'b1;
        rep_cnt_d   = '0;
        rep_first_d = 1'b0;
      end else begin
        rep_cnt_d = rep_cnt_q + 32'd1;
      end
    end

    // Blink restarts visible on state entry and after each adjust.
    if (state_chg || fire) begin
      blink_cnt_d = '0;
      phase_off_d = 1'b0;
    end else if (blink_cnt_q + 32'd1 == BLINK_MAX) begin
      blink_cnt_d = '0;
      phase_off_d = !phase_off_q;
    end else begin
      blink_cnt_d = blink_cnt_q + 32'd1;
    end

    adj_hour_d   = fire && hour_fld;
    adj_min_d    = fire && !hour_fld;
    sec_clr_d    = (state_q == ST_T_MIN) && state_chg;
    blank_hour_d = phase_off_d && is_hour(state_d);
    blank_min_d  = phase_off_d && is_min(state_d);
    set_al_d     = (state_d == ST_A_HOUR) || (state_d == ST_A_MIN);
    run_en_d     = !((state_d == ST_T_HOUR) || (state_d == ST_T_MIN));
  end

  // All state and registered outputs; async reset returns to RUN idle.
  always_ff @(posedge clk_50 or negedge ncr) begin
    if (!ncr) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      deb_q        <= '0;
      deb_cnt_q    <= '0;
      press_q      <= '0;
      state_q      <= ST_RUN;
      to_cnt_q     <= '0;
      rep_cnt_q    <= '0;
      rep_arm_q    <= 1'b0;
      rep_first_q  <= 1'b0;
      blink_cnt_q  <= '0;
      phase_off_q  <= 1'b0;
      set_al_q     <= 1'b0;
      run_en_q     <= 1'b1;
      adj_min_q    <= 1'b0;
      adj_hour_q   <= 1'b0;
      sec_clr_q    <= 1'b0;
      blank_min_q  <= 1'b0;
      blank_hour_q <= 1'b0;
    end else begin
      sync1_q      <= {key_inc, key_mode};
      sync2_q      <= sync1_q;
      deb_q        <= deb_d;
      deb_cnt_q    <= deb_cnt_d;
      press_q      <= press_d;
      state_q      <= state_d;
      to_cnt_q     <= to_cnt_d;
      rep_cnt_q    <= rep_cnt_d;
      rep_arm_q    <= rep_arm_d;
      rep_first_q  <= rep_first_d;
      blink_cnt_q  <= blink_cnt_d;
      phase_off_q  <= phase_off_d;
      set_al_q     <= set_al_d;
      run_en_q     <= run_en_d;
      adj_min_q    <= adj_min_d;
      adj_hour_q   <= adj_hour_d;
      sec_clr_q    <= sec_clr_d;
      blank_min_q  <= blank_min_d;
      blank_hour_q <= blank_hour_d;
    end
  end

  assign mode       = state_q;
  assign set_al     = set_al_q;
  assign run_en     = run_en_q;
  assign adj_min    = adj_min_q;
  assign adj_hour   = adj_hour_q;
  assign sec_clr    = sec_clr_q;
  assign blank_min  = blank_min_q;
  assign blank_hour = blank_hour_q;

endmodule
